// File: rtl/touch_adc_spi.sv
// touch_adc_spi: SPI master for an AD7843-compatible 12-bit touch-panel ADC.
// On pen-down it converts X then Y, commits both coordinates in one clock
// with a COORD_VALID pulse, then idles GAP_CYCLES clocks before the next pair.
// Optional build macro TOUCH_AVG4_EN: four back-to-back pairs are summed and
// their truncated mean is committed once per burst.
module touch_adc_spi #(
  parameter int unsigned CLK_DIV    = 25,
  parameter int unsigned GAP_CYCLES = 500000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        ADC_PENIRQ_n,
  input  logic        ADC_DOUT,
  output logic        ADC_DCLK,
  output logic        ADC_CS_n,
  output logic        ADC_DIN,
  output logic [11:0] X_COORD,
  output logic [11:0] Y_COORD,
  output logic        COORD_VALID,
  output logic        PEN_DOWN
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_CONV_X = 3'd1;
  localparam logic [2:0] ST_CONV_Y = 3'd2;
  localparam logic [2:0] ST_COMMIT = 3'd3;
  localparam logic [2:0] ST_GAP    = 3'd4;

  // 12-bit mode, differential reference, power-down bits 00
  localparam logic [7:0] CMD_X = 8'hD0;
  localparam logic [7:0] CMD_Y = 8'h90;

  // Half-periods 0..47 carry the 24 DCLK cycles; half 48 is the CS_n-high tail.
  localparam logic [5:0] HALF_LAST   = 6'd48;
  localparam logic [5:0] HALF_SMP_LO = 6'd19;  // rising edge 10
  localparam logic [5:0] HALF_SMP_HI = 6'd41;  // rising edge 21
  localparam logic [5:0] HALF_CMD_END = 6'd16; // after the 8 command bits

  logic [2:0]       state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [5:0]       half_q, half_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic             dclk_q, dclk_d;
  logic             cs_n_q, cs_n_d;
  logic             din_q, din_d;
  logic [11:0]      shift_q, shift_d;
  logic [11:0]      x_tmp_q, x_tmp_d;
  logic [11:0]      x_coord_q, x_coord_d;
  logic [11:0]      y_coord_q, y_coord_d;
  logic             valid_q, valid_d;
  logic             pen_meta_q, pen_meta_d;
  logic             pen_sync_q, pen_sync_d;
  logic             pen_down_q, pen_down_d;
`ifdef TOUCH_AVG4_EN
  logic [1:0]       pair_q, pair_d;
  logic [13:0]      acc_x_q, acc_x_d;
  logic [13:0]      acc_y_q, acc_y_d;
`else
  logic [11:0]      y_tmp_q, y_tmp_d;
`endif

  logic             start_frame;
  logic [7:0]       start_cmd;
  logic [7:0]       cur_cmd;
  logic [5:0]       half_nxt;
  logic             div_end;
  logic             frame_end;

  // Next-state logic: pen qualification, frame sequencing and the FSM
  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    half_d      = half_q;
    gap_d       = gap_q;
    dclk_d      = dclk_q;
    cs_n_d      = cs_n_q;
    din_d       = din_q;
    shift_d     = shift_q;
    x_tmp_d     = x_tmp_q;
    x_coord_d   = x_coord_q;
    y_coord_d   = y_coord_q;
    valid_d     = 1'b0;
    pen_meta_d  = ADC_PENIRQ_n;
    pen_sync_d  = pen_meta_q;
    // PENIRQ_n is undefined while the ADC is converting, so only track it
    // while chip select is released
    pen_down_d  = cs_n_q ? ~pen_sync_q : pen_down_q;
`ifdef TOUCH_AVG4_EN
    pair_d      = pair_q;
    acc_x_d     = acc_x_q;
    acc_y_d     = acc_y_q;
`else
    y_tmp_d     = y_tmp_q;
`endif
    start_frame = 1'b0;
    start_cmd   = CMD_X;
    cur_cmd     = (state_q == ST_CONV_Y) ? CMD_Y : CMD_X;
    half_nxt    = half_q + 6'd1;
    div_end     = (div_q == DIV_LAST);
    frame_end   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (pen_down_q) begin
          state_d     = ST_CONV_X;
          start_frame = 1'b1;
          start_cmd   = CMD_X;
        end
      end

      ST_CONV_X, ST_CONV_Y: begin
        if (div_end) begin
          div_d = '0;
          if (half_q == HALF_LAST) begin
            frame_end = 1'b1;
          end else begin
            half_d = half_nxt;
            if (half_nxt[0]) begin
              // rising DCLK edge (half_nxt+1)/2; data bits land on edges 10..21
              dclk_d = 1'b1;
              if (half_nxt >= HALF_SMP_LO && half_nxt <= HALF_SMP_HI) begin
                shift_d = {shift_q[10:0], ADC_DOUT};
              end
            end else begin
              dclk_d = 1'b0;
              if (half_nxt == HALF_LAST) begin
                cs_n_d = 1'b1;
                din_d  = 1'b0;
              end else if (half_nxt < HALF_CMD_END) begin
                // low half k = half_nxt/2 presents bit 7-k, i.e. index ~k
                din_d = cur_cmd[~half_nxt[3:1]];
              end else begin
                din_d = 1'b0;
              end
            end
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end

        if (frame_end) begin
          if (state_q == ST_CONV_X) begin
            x_tmp_d     = shift_q;
            state_d     = ST_CONV_Y;
            start_frame = 1'b1;
            start_cmd   = CMD_Y;
          end else begin
`ifdef TOUCH_AVG4_EN
            acc_x_d = acc_x_q + {2'b00, x_tmp_q};
            acc_y_d = acc_y_q + {2'b00, shift_q};
            if (pair_q == 2'd3) begin
              pair_d  = '0;
              state_d = ST_COMMIT;
            end else begin
              pair_d      = pair_q + 2'd1;
              state_d     = ST_CONV_X;
              start_frame = 1'b1;
              start_cmd   = CMD_X;
            end
`else
            y_tmp_d = shift_q;
            state_d = ST_COMMIT;
`endif
          end
        end
      end

      ST_COMMIT: begin
`ifdef TOUCH_AVG4_EN
        x_coord_d = acc_x_q[13:2];
        y_coord_d = acc_y_q[13:2];
        acc_x_d   = '0;
        acc_y_d   = '0;
`else
        x_coord_d = x_tmp_q;
        y_coord_d = y_tmp_q;
`endif
        valid_d = 1'b1;
        gap_d   = '0;
        state_d = ST_GAP;
      end

      ST_GAP: begin
        if (gap_q == GAP_LAST) begin
          gap_d = '0;
          if (pen_down_q) begin
            state_d     = ST_CONV_X;
            start_frame = 1'b1;
            start_cmd   = CMD_X;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
        cs_n_d  = 1'b1;
        dclk_d  = 1'b0;
        din_d   = 1'b0;
      end
    endcase

    // Frame entry: CS_n low with the command MSB already on DIN
    if (start_frame) begin
      div_d  = '0;
      half_d = '0;
      dclk_d = 1'b0;
      cs_n_d = 1'b0;
      din_d  = start_cmd[7];
    end
  end

  // State registers; reset aborts any frame and drops CS_n at once
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= ST_IDLE;
      div_q      <= '0;
      half_q     <= '0;
      gap_q      <= '0;
      dclk_q     <= 1'b0;
      cs_n_q     <= 1'b1;
      din_q      <= 1'b0;
      shift_q    <= '0;
      x_tmp_q    <= '0;
      x_coord_q  <= '0;
      y_coord_q  <= '0;
      valid_q    <= 1'b0;
      pen_meta_q <= 1'b1;
      pen_sync_q <= 1'b1;
      pen_down_q <= 1'b0;
`ifdef TOUCH_AVG4_EN
      pair_q     <= '0;
      acc_x_q    <= '0;
      acc_y_q    <= '0;
`else
      y_tmp_q    <= '0;
`endif
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      half_q     <= half_d;
      gap_q      <= gap_d;
      dclk_q     <= dclk_d;
      cs_n_q     <= cs_n_d;
      din_q      <= din_d;
      shift_q    <= shift_d;
      x_tmp_q    <= x_tmp_d;
      x_coord_q  <= x_coord_d;
      y_coord_q  <= y_coord_d;
      valid_q    <= valid_d;
      pen_meta_q <= pen_meta_d;
      pen_sync_q <= pen_sync_d;
      pen_down_q <= pen_down_d;
`ifdef TOUCH_AVG4_EN
      pair_q     <= pair_d;
      acc_x_q    <= acc_x_d;
      acc_y_q    <= acc_y_d;
`else
      y_tmp_q    <= y_tmp_d;
`endif
    end
  end

  assign ADC_DCLK    = dclk_q;
  assign ADC_CS_n    = cs_n_q;
  assign ADC_DIN     = din_q;
  assign X_COORD     = x_coord_q;
  assign Y_COORD     = y_coord_q;
  assign COORD_VALID = valid_q;
  assign PEN_DOWN    = pen_down_q;

endmodule

// File: tb/tb_touch_adc_spi.sv
// tb_touch_adc_spi: directed bench for touch_adc_spi with a behavioural
// AD7843-style ADC model. Build with TOUCH_AVG4_EN to exercise averaging.
module tb_touch_adc_spi;

  localparam int unsigned D     = 4;
  localparam int unsigned GAP   = 200;
`ifdef TOUCH_AVG4_EN
  localparam int unsigned PAIRS = 4;
`else
  localparam int unsigned PAIRS = 1;
`endif
  localparam int unsigned FRAME    = 49 * D;
  localparam int unsigned BURST    = 2 * PAIRS * FRAME;
  localparam int unsigned INTERVAL = 1 + GAP + BURST;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        ADC_PENIRQ_n = 1'b1;
  logic        ADC_DOUT = 1'b0;
  logic        ADC_DCLK, ADC_CS_n, ADC_DIN, COORD_VALID, PEN_DOWN;
  logic [11:0] X_COORD, Y_COORD;

  int vectors = 0;
  int miscompares = 0;

  touch_adc_spi #(.CLK_DIV(D), .GAP_CYCLES(GAP)) dut (
    .CLK(CLK), .RST(RST), .ADC_PENIRQ_n(ADC_PENIRQ_n), .ADC_DOUT(ADC_DOUT),
    .ADC_DCLK(ADC_DCLK), .ADC_CS_n(ADC_CS_n), .ADC_DIN(ADC_DIN),
    .X_COORD(X_COORD), .Y_COORD(Y_COORD), .COORD_VALID(COORD_VALID),
    .PEN_DOWN(PEN_DOWN)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- ADC model ----------------
  logic [11:0] x_list [4];
  logic [11:0] y_list [4];
  logic [7:0]  cmd_log [$];
  int          edge_log [$];
  int          edge_n = 0, frame_cnt = 0, dclk_rises = 0, x_idx = 0, y_idx = 0;
  logic [7:0]  cmd_sh = '0;
  logic        dclk_prev = 1'b0, cs_prev = 1'b1;
  logic [11:0] word;

  // DIN captured on DCLK rise, DOUT changed after DCLK fall
  always @(negedge CLK) begin
    if (ADC_DCLK && !dclk_prev) dclk_rises++;
    if (cs_prev && !ADC_CS_n) begin
      edge_n = 0;
      cmd_sh = '0;
      frame_cnt++;
    end
    if (!ADC_CS_n && ADC_DCLK && !dclk_prev) begin
      edge_n++;
      if (edge_n <= 8) cmd_sh = {cmd_sh[6:0], ADC_DIN};
    end
    if (!ADC_CS_n && !ADC_DCLK && dclk_prev) begin
      word = (cmd_sh == 8'hD0) ? x_list[x_idx] : (cmd_sh == 8'h90) ? y_list[y_idx] : 12'h000;
      if (edge_n >= 9 && edge_n <= 20) ADC_DOUT = word[20 - edge_n];
      else ADC_DOUT = 1'b0;
    end
    if (!cs_prev && ADC_CS_n) begin
      cmd_log.push_back(cmd_sh);
      edge_log.push_back(edge_n);
      ADC_DOUT = 1'b0;
      if (!RST) begin
        if (cmd_sh == 8'hD0) x_idx = (x_idx + 1) % 4;
        else if (cmd_sh == 8'h90) y_idx = (y_idx + 1) % 4;
      end
    end
    if (RST) begin
      x_idx = 0;
      y_idx = 0;
    end
    dclk_prev = ADC_DCLK;
    cs_prev   = ADC_CS_n;
  end

  // ---------------- output monitor ----------------
  int          cyc = 0;
  int          valid_cnt = 0, pen_rise_cyc = -1, bad_upd = 0, long_pulse = 0;
  logic        valid_prev = 1'b0, pen_prev = 1'b0;
  logic [11:0] x_prev = '0, y_prev = '0;

  always @(posedge CLK) cyc++;

  always @(negedge CLK) begin
    if (COORD_VALID) valid_cnt++;
    if (COORD_VALID && valid_prev) long_pulse++;
    if (PEN_DOWN && !pen_prev && pen_rise_cyc < 0) pen_rise_cyc = cyc;
    if (!RST && !COORD_VALID && (X_COORD != x_prev || Y_COORD != y_prev)) bad_upd++;
    valid_prev = COORD_VALID;
    pen_prev   = PEN_DOWN;
    x_prev     = X_COORD;
    y_prev     = Y_COORD;
  end

  task automatic set_pair(input logic [11:0] x, input logic [11:0] y);
    for (int i = 0; i < 4; i++) begin
      x_list[i] = x;
      y_list[i] = y;
    end
  endtask

  task automatic wait_valid(input string tag, input int budget);
    int n;
    n = 0;
    while (!COORD_VALID && n < budget) begin
      @(negedge CLK);
      n++;
    end
    if (!COORD_VALID) check({tag, "_timeout"}, 32'(0), 32'(1));
  endtask

  int t_prev, t_now, fc, vc, n, k;
  logic dprev;

  initial begin
    set_pair(12'h000, 12'h000);

    // reset values
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("rst_dclk",  32'(ADC_DCLK), 0);
    check("rst_cs_n",  32'(ADC_CS_n), 1);
    check("rst_din",   32'(ADC_DIN), 0);
    check("rst_x",     32'(X_COORD), 0);
    check("rst_y",     32'(Y_COORD), 0);
    check("rst_valid", 32'(COORD_VALID), 0);
    check("rst_pen",   32'(PEN_DOWN), 0);

    // idle with pen up
    RST = 1'b0;
    repeat (10000) @(negedge CLK);
    check("idle_cs_n",   32'(ADC_CS_n), 1);
    check("idle_dclk",   32'(dclk_rises), 0);
    check("idle_frames", 32'(frame_cnt), 0);
    check("idle_pen",    32'(PEN_DOWN), 0);

    // basic conversion
    set_pair(12'hA5C, 12'h3F1);
    ADC_PENIRQ_n = 1'b0;
    wait_valid("basic", BURST + 100);
    t_now = cyc;
    check("basic_x", 32'(X_COORD), 'hA5C);
    check("basic_y", 32'(Y_COORD), 'h3F1);
    check("basic_latency", 32'((t_now - pen_rise_cyc) >= int'(BURST) &&
                               (t_now - pen_rise_cyc) <= int'(BURST) + 2), 1);
    check("cmd_x",   32'(cmd_log[0]), 'hD0);
    check("cmd_y",   32'(cmd_log[1]), 'h90);
    check("edges_x", 32'(edge_log[0]), 24);
    check("edges_y", 32'(edge_log[1]), 24);
    @(negedge CLK);
    check("basic_valid_width", 32'(COORD_VALID), 0);
    check("basic_pen", 32'(PEN_DOWN), 1);

    // bit extremes with the pen held through the gaps
    t_prev = t_now;
    set_pair(12'h000, 12'hFFF);
    wait_valid("ext1", INTERVAL + 100);
    t_now = cyc;
    check("ext1_x", 32'(X_COORD), 'h000);
    check("ext1_y", 32'(Y_COORD), 'hFFF);
    check("ext1_interval", 32'(t_now - t_prev), INTERVAL);
    @(negedge CLK);
    t_prev = t_now;
    set_pair(12'hFFF, 12'h000);
    wait_valid("ext2", INTERVAL + 100);
    t_now = cyc;
    check("ext2_x", 32'(X_COORD), 'hFFF);
    check("ext2_y", 32'(Y_COORD), 'h000);
    check("ext2_interval", 32'(t_now - t_prev), INTERVAL);
    @(negedge CLK);
    check("three_pulses", 32'(valid_cnt), 3);

    // pen released during the Y frame: pair still committed, then idle
    set_pair(12'h123, 12'h456);
    fc = frame_cnt;
    n = 0;
    while (frame_cnt < fc + 2 && n < int'(INTERVAL) + 100) begin
      @(negedge CLK);
      n++;
    end
    check("rel_reach_y", 32'(frame_cnt >= fc + 2), 1);
    repeat (8) @(negedge CLK);
    ADC_PENIRQ_n = 1'b1;
    wait_valid("rel", BURST + 100);
    check("rel_x", 32'(X_COORD), 'h123);
    check("rel_y", 32'(Y_COORD), 'h456);
    repeat (GAP + 2 * FRAME) @(negedge CLK);
    check("rel_pen",    32'(PEN_DOWN), 0);
    check("rel_cs_n",   32'(ADC_CS_n), 1);
    check("rel_frames", 32'(frame_cnt - fc), 2 * PAIRS);
    check("rel_pulses", 32'(valid_cnt), 4);

    // reset at rising DCLK edge 15 of the X frame
    vc = valid_cnt;
    fc = frame_cnt;
    ADC_PENIRQ_n = 1'b0;
    n = 0;
    k = 0;
    dprev = ADC_DCLK;
    while (k < 15 && n < 1000) begin
      @(negedge CLK);
      n++;
      if (!ADC_CS_n && ADC_DCLK && !dprev) k++;
      dprev = ADC_DCLK;
    end
    check("mid_reach_edge15", 32'(k), 15);
    RST = 1'b1;
    #1;
    check("mid_cs_n",  32'(ADC_CS_n), 1);
    check("mid_dclk",  32'(ADC_DCLK), 0);
    check("mid_x",     32'(X_COORD), 0);
    check("mid_y",     32'(Y_COORD), 0);
    ADC_PENIRQ_n = 1'b1;
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    repeat (1000) @(negedge CLK);
    check("mid_no_valid", 32'(valid_cnt - vc), 0);
    check("mid_frames",   32'(frame_cnt - fc), 1);
    check("mid_abort_edges", 32'(edge_log[edge_log.size() - 1]), 15);
    check("mid_x_after", 32'(X_COORD), 0);
    check("mid_y_after", 32'(Y_COORD), 0);

`ifdef TOUCH_AVG4_EN
    // averaging: X=100..103 -> 406>>2 = 101, Y=7FF x4 -> 7FF
    x_list[0] = 12'h100;
    x_list[1] = 12'h101;
    x_list[2] = 12'h102;
    x_list[3] = 12'h103;
    for (int i = 0; i < 4; i++) y_list[i] = 12'h7FF;
    vc = valid_cnt;
    ADC_PENIRQ_n = 1'b0;
    wait_valid("avg", BURST + 100);
    check("avg_x", 32'(X_COORD), 'h101);
    check("avg_y", 32'(Y_COORD), 'h7FF);
    ADC_PENIRQ_n = 1'b1;
    repeat (GAP + 2 * FRAME) @(negedge CLK);
    check("avg_pulses", 32'(valid_cnt - vc), 1);
`endif

    check("no_update_without_valid", 32'(bad_upd), 0);
    check("valid_single_cycle", 32'(long_pulse), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish within 3000000 ns");
    $fatal(1, "watchdog expired");
  end

endmodule
